alu_cmd_driver: RTL and testbench

Sequential command front-end that initiates operations on the 4-bit combinational ALU and returns its results. Accepts operand/opcode commands over a valid/ready handshake, drives the ALU operand and select inputs from registers, samples the ALU result one cycle later, and presents it on a valid/ready result port. Sits between the datapath control logic and the ALU, and supports chaining so that the previous result is reused as operand A.

---
 rtl/alu_cmd_driver.sv | 104 ++++++++++
 tb/tb_alu_cmd_driver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// ----------------------------------------------------------------------------
// alu_cmd_driver
//
// Sequential command front-end for a 4-bit combinational ALU. It accepts one
// operand/opcode command at a time over a valid/ready handshake and drives the
// ALU inputs from registers. It samples the ALU result one cycle later and
// presents that result on a valid/ready result port. Chained commands reuse
// the previous result as operand A.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  driver can accept a command (IDLE only)
//   cmd_a      operand A (ignored when cmd_chain=1)
//   cmd_b      operand B / shift amount
//   cmd_op     00 add, 01 sub, 10 shift-left, 11 AND
//   cmd_chain  use the last captured result as operand A
//   alu_a      registered ALU operand A
//   alu_b      registered ALU operand B
//   alu_s      registered ALU select (equals the accepted cmd_op)
//   alu_f      ALU result, combinational from alu_a/alu_b/alu_s
//   res_valid  result present (RESP only)
//   res_ready  consumer accepts the result
//   res_data   captured ALU result
//   res_op     opcode that produced res_data
//   op_count   completed results, modulo 256
// ----------------------------------------------------------------------------
module alu_cmd_driver (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   input  logic [1:0] cmd_op,
   input  logic       cmd_chain,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [1:0] alu_s,
   input  logic [3:0] alu_f,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [3:0] res_data,
   output logic [1:0] res_op,
   output logic [7:0] op_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t     state_reg;
   logic [3:0] last_res_reg;

   // Both handshake outputs decode the state register only. As a result, no
   // combinational path runs from any input to the command or result side.
   assign cmd_ready = (state_reg == IDLE);
   assign res_valid = (state_reg == RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         last_res_reg <= 4'd0;
         alu_a        <= 4'd0;
         alu_b        <= 4'd0;
         alu_s        <= 2'd0;
         res_data     <= 4'd0;
         res_op       <= 2'd0;
         op_count     <= 8'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               // The ALU inputs change only when a command is accepted. They
               // stay quiet while the driver is idle.
               if (cmd_valid) begin
                  alu_a     <= cmd_chain ? last_res_reg : cmd_a;
                  alu_b     <= cmd_b;
                  alu_s     <= cmd_op;
                  res_op    <= cmd_op;
                  state_reg <= DRIVE;
               end
            end
            DRIVE: begin
               // The ALU has had one full cycle with stable inputs, so alu_f
               // is captured here verbatim. No local recomputation is done.
               res_data     <= alu_f;
               last_res_reg <= alu_f;
               state_reg    <= RESP;
            end
            RESP: begin
               if (res_ready) begin
                  op_count  <= op_count + 8'd1;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic [1:0] cmd_op;
   logic       cmd_chain;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [1:0] alu_s;
   logic [3:0] alu_f;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_data;
   logic [1:0] res_op;
   logic [7:0] op_count;

   int total;
   int bad;
   int exp_count;

   alu_cmd_driver dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_op    (cmd_op),
      .cmd_chain (cmd_chain),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_s     (alu_s),
      .alu_f     (alu_f),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_op    (res_op),
      .op_count  (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stand-in for the external combinational ALU.
   always_comb begin
      alu_f = 4'd0;
      case (alu_s)
         2'b00: alu_f = alu_a + alu_b;
         2'b01: alu_f = alu_a - alu_b;
         2'b10: alu_f = (alu_b >= 4'd4) ? 4'd0 : (alu_a << alu_b);
         2'b11: alu_f = alu_a & alu_b;
         default: alu_f = 4'd0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Present a command and wait for acceptance. The task returns 1 time unit
   // after the accepting edge, which leaves the driver in DRIVE.
   task automatic start_cmd(input logic [3:0] a, input logic [3:0] b,
                            input logic [1:0] op, input logic chain);
      int n;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      cmd_chain = chain;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic do_cmd(input string name, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op, input logic chain,
                         input logic [3:0] exp_a, input logic [3:0] exp_res);
      start_cmd(a, b, op, chain);
      check({name, "_alu_a"}, alu_a, exp_a);
      check({name, "_alu_b"}, alu_b, b);
      check({name, "_alu_s"}, alu_s, op);
      check({name, "_drive_nvalid"}, res_valid, 0);
      check({name, "_drive_nready"}, cmd_ready, 0);
      @(posedge clk);
      #1;
      check({name, "_res_valid"}, res_valid, 1);
      check({name, "_res_data"}, res_data, exp_res);
      check({name, "_res_op"}, res_op, op);
      @(posedge clk);
      #1;
      exp_count = (exp_count + 1) % 256;
      check({name, "_op_count"}, op_count, exp_count);
      check({name, "_back_idle"}, cmd_ready, 1);
      $display("txn %s: a=%0h b=%0h op=%0d chain=%0d -> res=%0h count=%0d",
               name, alu_a, b, op, chain, res_data, op_count);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      exp_count = 0;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_a     = 4'd0;
      cmd_b     = 4'd0;
      cmd_op    = 2'd0;
      cmd_chain = 1'b0;
      res_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_op", res_op, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_alu_s", alu_s, 0);
      check("rst_op_count", op_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      do_cmd("add",   4'h5, 4'h3, 2'b00, 1'b0, 4'h5, 4'h8);
      do_cmd("sub",   4'h3, 4'h5, 2'b01, 1'b0, 4'h3, 4'hE);
      do_cmd("addwr", 4'hF, 4'h1, 2'b00, 1'b0, 4'hF, 4'h0);
      do_cmd("shl",   4'h3, 4'h2, 2'b10, 1'b0, 4'h3, 4'hC);
      do_cmd("shl4",  4'h1, 4'h4, 2'b10, 1'b0, 4'h1, 4'h0);
      do_cmd("and",   4'hA, 4'h6, 2'b11, 1'b0, 4'hA, 4'h2);
      do_cmd("ch0",   4'h2, 4'h3, 2'b00, 1'b0, 4'h2, 4'h5);
      do_cmd("ch1",   4'hE, 4'h1, 2'b01, 1'b1, 4'h5, 4'h4);

      // Backpressure: the result is held while a second command waits.
      res_ready = 1'b0;
      start_cmd(4'h4, 4'h4, 2'b00, 1'b0);
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_a     = 4'h9;
      cmd_b     = 4'h3;
      cmd_op    = 2'b11;
      cmd_chain = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_res_valid", res_valid, 1);
         check("bp_res_data", res_data, 4'h8);
         check("bp_cmd_ready", cmd_ready, 0);
         check("bp_alu_a_held", alu_a, 4'h4);
         @(posedge clk);
         #1;
      end
      check("bp_still_valid", res_valid, 1);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      exp_count = (exp_count + 1) % 256;
      check("bp_release_idle", cmd_ready, 1);
      check("bp_op_count", op_count, exp_count);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check("bp2_alu_a", alu_a, 4'h9);
      check("bp2_alu_s", alu_s, 2'b11);
      @(posedge clk);
      #1;
      check("bp2_res_data", res_data, 4'h1);
      check("bp2_res_op", res_op, 2'b11);
      @(posedge clk);
      #1;
      exp_count = (exp_count + 1) % 256;
      check("bp2_op_count", op_count, exp_count);
      $display("txn backpressure: held 5 cycles, second res=%0h count=%0d", res_data, op_count);

      // Reset asserted while a result is pending in RESP.
      res_ready = 1'b0;
      start_cmd(4'h6, 4'h1, 2'b00, 1'b0);
      @(posedge clk);
      #1;
      check("mr_in_resp", res_valid, 1);
      rst_n = 1'b0;
      #1;
      check("mr_res_valid", res_valid, 0);
      check("mr_res_data", res_data, 0);
      check("mr_op_count", op_count, 0);
      check("mr_alu_a", alu_a, 0);
      check("mr_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      rst_n     = 1'b1;
      exp_count = 0;
      @(posedge clk);
      #1;
      check("mr_post_nvalid", res_valid, 0);
      $display("txn midreset: outputs cleared, count=%0d", op_count);
      res_ready = 1'b1;

      // A chained command right after reset uses last_res = 0.
      do_cmd("chrst", 4'hF, 4'h7, 2'b00, 1'b1, 4'h0, 4'h7);

      // Run 255 more operations so that op_count wraps back to 0.
      for (int i = 0; i < 255; i++) begin
         do_cmd("wrap", 4'h1, 4'h1, 2'b00, 1'b0, 4'h1, 4'h2);
      end
      check("wrap_zero", op_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
